// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with 2-bit saturating counters.
// The FD stage looks up a prediction combinationally. The X stage trains
// the table with the resolved outcome. Two counters track resolved
// branches and mispredicted branches.
module branch_predictor #(
    parameter int LINES = 8,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_guess,
    input  logic            is_br_guess,
    output logic            pred_taken,
    output logic            pred_hit,
    input  logic [PC_W-1:0] pc_check,
    input  logic            is_br_check,
    input  logic            br_taken_check,
    input  logic            pred_check,
    output logic            mispredict,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = PC_W - IDX - 2;

    // Table state: one valid bit, tag and counter per line
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [1:0]       ctr_q [LINES];

    logic [IDX-1:0]   guess_idx;
    logic [TAG_W-1:0] guess_tag;
    logic [IDX-1:0]   check_idx;
    logic [TAG_W-1:0] check_tag;
    logic             check_hit;
    logic [1:0]       ctr_next;

    // Byte-offset bits of the PCs never take part in indexing
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

    assign guess_idx = pc_guess[IDX+1:2];
    assign guess_tag = pc_guess[PC_W-1:IDX+2];
    assign check_idx = pc_check[IDX+1:2];
    assign check_tag = pc_check[PC_W-1:IDX+2];

    // Lookup reads registered state only. An update in the same cycle
    // therefore becomes visible on the following cycle. The rst_n term keeps
    // the outputs low while reset is held.
    assign pred_hit   = rst_n & is_br_guess & valid_q[guess_idx]
                        & (tag_q[guess_idx] == guess_tag);
    assign pred_taken = pred_hit & ctr_q[guess_idx][1];

    assign mispredict = is_br_check & (br_taken_check ^ pred_check);

    assign check_hit  = valid_q[check_idx] & (tag_q[check_idx] == check_tag);

    // New counter value: saturating step on a hit, weak allocate on a miss
    always_comb begin
        ctr_next = ctr_q[check_idx];
        if (check_hit) begin
            if (br_taken_check) begin
                if (ctr_q[check_idx] != 2'b11) ctr_next = ctr_q[check_idx] + 2'b01;
            end else begin
                if (ctr_q[check_idx] != 2'b00) ctr_next = ctr_q[check_idx] - 2'b01;
            end
        end else begin
            ctr_next = br_taken_check ? 2'b10 : 2'b01;
        end
    end

    // Table training and statistics counters. Reset overrides a pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= 2'b00;
            end
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else if (is_br_check) begin
            valid_q[check_idx] <= 1'b1;
            tag_q[check_idx]   <= check_tag;
            ctr_q[check_idx]   <= ctr_next;
            br_count           <= br_count + 32'd1;
            if (mispredict) mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter LINES, default 8, number of direct-mapped history entries; SHALL be a power of two >= 2.
REQ-002 Parameter PC_W, default 32, width of PC inputs.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pc_guess  input  PC_W  PC of the FD-stage instruction being looked up.
REQ-006 is_br_guess  input  1  FD-stage instruction is a conditional branch (opcode 0x63).
REQ-007 pred_taken  output  1  prediction for pc_guess, consumed by control logic.
REQ-008 pred_hit  output  1  pc_guess found a valid, tag-matching entry.
REQ-009 pc_check  input  PC_W  PC of the X-stage instruction.
REQ-010 is_br_check  input  1  X-stage instruction is a conditional branch; qualifies update.
REQ-011 br_taken_check  input  1  resolved outcome of the X-stage branch.
REQ-012 pred_check  input  1  prediction made for the X-stage branch, carried down the pipe.
REQ-013 mispredict  output  1  X-stage branch outcome differs from pred_check.
REQ-014 br_count  output  32  resolved conditional branches since reset.
REQ-015 mispred_count  output  32  mispredicted branches since reset.

Function
REQ-016 Index SHALL be pc[IDX+1:2] and tag SHALL be pc[PC_W-1:IDX+2], with IDX = log2(LINES).
REQ-017 Each entry SHALL hold a valid bit, a tag, and a 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-018 Lookup SHALL be combinational, zero latency: pred_hit = is_br_guess & valid[idx] & (tag match).
REQ-019 pred_taken SHALL equal pred_hit & counter[idx][1]; on a miss or non-branch, pred_taken SHALL be 0.
REQ-020 Update SHALL occur on the rising edge only when is_br_check = 1; no state SHALL change otherwise.
REQ-021 Update hit (valid and tag match at pc_check index): counter increments toward 11 if taken, decrements toward 00 if not taken; saturates at both ends, no wrap.
REQ-022 Update miss: entry SHALL be allocated (valid=1, tag written), counter = 10 if taken, 01 if not taken; prior contents discarded.
REQ-023 Same-cycle lookup and update to the same index: lookup SHALL return the pre-update (registered) value; new value visible the next cycle.
REQ-024 mispredict SHALL be combinational: is_br_check & (br_taken_check != pred_check).
REQ-025 br_count SHALL increment by 1 on every edge with is_br_check = 1; mispred_count SHALL increment on every edge with mispredict = 1; both wrap modulo 2^32.
REQ-026 Aliasing: two PCs with equal index and different tag SHALL evict each other; no associativity.

Reset
REQ-027 rst_n low SHALL immediately, independent of clk, clear all valid bits, set all counters to 00, and clear br_count and mispred_count.
REQ-028 During reset pred_taken and pred_hit SHALL be 0; mispredict remains combinational from its inputs.
REQ-029 Reset asserted mid-update SHALL win; the update SHALL be discarded.
REQ-030 First update edge after rst_n rises SHALL be honoured normally.

Verification
REQ-031 Cold lookup: after reset, pc_guess=0x100, is_br_guess=1 -> pred_hit=0, pred_taken=0.
REQ-032 Allocate/train: update pc_check=0x100 taken -> lookup 0x100 gives hit=1, taken=1 (ctr 10); second taken -> ctr 11; two not-taken -> ctr 01, pred_taken=0.
REQ-033 Saturation: five taken updates to 0x40 -> ctr 11; one not-taken -> ctr 10, pred_taken still 1.
REQ-034 Aliasing (LINES=8): train 0x100 taken, then update 0x120 not-taken (same index 0) -> lookup 0x100 misses, 0x120 hits with taken=0.
REQ-035 Same-cycle bypass: entry 0x100 at ctr 01; in one cycle update 0x100 taken and lookup 0x100 -> pred_taken=0 that cycle, 1 next cycle.
REQ-036 Stats/reset: 3 branches, 2 with pred_check != br_taken_check -> br_count=3, mispred_count=2; pulse rst_n low between edges -> both 0 and all lookups miss immediately.
